spi_slave_burst_controller: RTL and testbench

Next-generation SPI slave protocol controller. Sits between the SPI RX/TX shift registers and the memory-side bus adapter. Decodes 8-bit commands and supports burst read/write with address auto-increment and optional wrap. Owns an internal four-entry config/status register file. Adds TX underrun detection over the previous controller. All logic runs on the SPI clock domain.

---
 rtl/spi_slave_burst_controller.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_spi_slave_burst_controller.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_burst_controller.sv
// SPI slave command/burst controller: decodes commands, drives bus
// strobes with address auto-increment/wrap, owns config/status regs.
module spi_slave_burst_controller #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter logic [7:0] DUMMY_CYCLES = 8'd7,
  parameter logic [DATA_WIDTH-1:0] UNDERRUN_DATA = '0,
  localparam int RX_WIDTH =
    (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH
) (
  input  logic                  sclk,
  input  logic                  sys_rst,
  input  logic                  cs,
  output logic [7:0]            rx_counter,
  output logic                  rx_counter_upd,
  input  logic [RX_WIDTH-1:0]   rx_data,
  input  logic                  rx_data_valid,
  output logic [7:0]            tx_counter,
  output logic                  tx_counter_upd,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_done,
  output logic                  ctrl_rd_wr,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic                  ctrl_addr_valid,
  output logic [DATA_WIDTH-1:0] ctrl_data_rx,
  output logic                  ctrl_data_rx_valid,
  input  logic [DATA_WIDTH-1:0] ctrl_data_tx,
  input  logic                  ctrl_data_tx_valid,
  output logic                  ctrl_data_tx_ready,
  output logic [15:0]           wrap_length,
  output logic                  underrun
);

  localparam logic [7:0] AW_M1 = 8'(ADDR_WIDTH - 1);
  localparam logic [7:0] DW_M1 = 8'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA_RX,
    S_DATA_TX,
    S_REG_RX,
    S_REG_TX,
    S_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic                  is_read_q, is_read_d;
  logic [1:0]            reg_sel_q, reg_sel_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  addr_vld_q, addr_vld_d;
  logic [7:0]            rx_cnt_q, rx_cnt_d;
  logic [7:0]            tx_cnt_q, tx_cnt_d;
  logic                  tx_upd_q, tx_upd_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  pop_q, pop_d;
  logic                  tx_done_q;
  logic [7:0]            dummy_q, dummy_d;
  logic [15:0]           wrap_q, wrap_d;
  logic                  underrun_q, underrun_d;

  logic                  rx_upd;
  logic                  wr_strobe;
  logic                  mem_load;
  logic                  reg_load;
  logic                  advance;
  logic                  set_ur;
  logic                  clr_ur;
  logic [7:0]            cmd;
  logic [7:0]            reg_rd;
  logic [ADDR_WIDTH-1:0] offset_inc;
  logic [ADDR_WIDTH-1:0] offset_nxt;

  assign cmd = rx_data[7:0];

  always_comb begin
    reg_rd = 8'h00;
    unique case (cmd[1:0])
      2'd0: reg_rd = dummy_q;
      2'd1: reg_rd = wrap_q[7:0];
      2'd2: reg_rd = wrap_q[15:8];
      2'd3: reg_rd = {7'b0, underrun_q};
    endcase
  end

  // Wrap is relative to the burst base, not address-aligned.
  always_comb begin
    offset_inc = offset_q + STEP;
    offset_nxt = offset_inc;
    if (wrap_q != 16'd0 &&
        32'(offset_inc) >= 32'(wrap_q))
      offset_nxt = '0;
  end

  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    reg_sel_d  = reg_sel_q;
    rx_cnt_d   = rx_cnt_q;
    dummy_d    = dummy_q;
    wrap_d     = wrap_q;
    rx_upd     = 1'b0;
    wr_strobe  = 1'b0;
    mem_load   = 1'b0;
    reg_load   = 1'b0;
    advance    = 1'b0;
    clr_ur     = 1'b0;
    unique case (state_q)
      S_CMD: begin
        if (rx_data_valid) begin
          unique case (1'b1)
            cmd == 8'h02: begin
              state_d   = S_ADDR;
              is_read_d = 1'b0;
              rx_cnt_d  = AW_M1;
              rx_upd    = 1'b1;
            end
            cmd == 8'h0B: begin
              state_d   = S_ADDR;
              is_read_d = 1'b1;
              rx_cnt_d  = AW_M1;
              rx_upd    = 1'b1;
            end
            cmd[7:2] == 6'b000100: begin
              state_d   = S_REG_RX;
              reg_sel_d = cmd[1:0];
              rx_cnt_d  = 8'd7;
              rx_upd    = 1'b1;
            end
            cmd[7:2] == 6'b001000: begin
              state_d   = S_REG_TX;
              reg_sel_d = cmd[1:0];
              reg_load  = 1'b1;
            end
            default: state_d = S_IGNORE;
          endcase
        end
      end
      S_ADDR: begin
        if (rx_data_valid) begin
          rx_upd = 1'b1;
          if (is_read_q) begin
            state_d  = S_DUMMY;
            rx_cnt_d = dummy_q;
          end else begin
            state_d  = S_DATA_RX;
            rx_cnt_d = DW_M1;
          end
        end
      end
      S_DUMMY: begin
        if (rx_data_valid) begin
          state_d  = S_DATA_TX;
          mem_load = 1'b1;
        end
      end
      S_DATA_RX: begin
        if (rx_data_valid) begin
          wr_strobe = 1'b1;
          advance   = 1'b1;
          rx_cnt_d  = DW_M1;
          rx_upd    = 1'b1;
        end
      end
      S_DATA_TX: begin
        if (tx_done_q) begin
          advance  = 1'b1;
          mem_load = 1'b1;
        end
      end
      S_REG_RX: begin
        if (rx_data_valid) begin
          unique case (reg_sel_q)
            2'd0: dummy_d = cmd;
            2'd1: wrap_d[7:0] = cmd;
            2'd2: wrap_d[15:8] = cmd;
            2'd3: clr_ur = cmd[0];
          endcase
          state_d  = S_CMD;
          rx_cnt_d = 8'd7;
          rx_upd   = 1'b1;
        end
      end
      S_REG_TX: begin
        if (tx_done_q)
          state_d = S_CMD;
      end
      S_IGNORE: state_d = S_IGNORE;
    endcase
  end

  always_comb begin
    base_d     = base_q;
    offset_d   = offset_q;
    addr_d     = addr_q;
    addr_vld_d = 1'b0;
    tx_cnt_d   = tx_cnt_q;
    tx_upd_d   = 1'b0;
    tx_data_d  = tx_data_q;
    pop_d      = 1'b0;
    set_ur     = 1'b0;
    if (state_q == S_ADDR && rx_data_valid) begin
      base_d     = rx_data[ADDR_WIDTH-1:0];
      offset_d   = '0;
      addr_d     = rx_data[ADDR_WIDTH-1:0];
      addr_vld_d = 1'b1;
    end
    if (advance) begin
      offset_d   = offset_nxt;
      addr_d     = base_q + offset_nxt;
      addr_vld_d = 1'b1;
    end
    if (mem_load) begin
      tx_upd_d = 1'b1;
      tx_cnt_d = DW_M1;
      if (ctrl_data_tx_valid) begin
        tx_data_d = ctrl_data_tx;
        pop_d     = 1'b1;
      end else begin
        tx_data_d = UNDERRUN_DATA;
        set_ur    = 1'b1;
      end
    end
    if (reg_load) begin
      tx_upd_d  = 1'b1;
      tx_cnt_d  = 8'd7;
      tx_data_d = DATA_WIDTH'(reg_rd);
    end
    // A same-cycle set wins over a software clear.
    underrun_d = set_ur ? 1'b1 :
                 clr_ur ? 1'b0 : underrun_q;
  end

  always_ff @(posedge sclk) begin
    if (sys_rst || cs)
      state_q <= S_CMD;
    else
      state_q <= state_d;
  end

  always_ff @(posedge sclk) begin
    if (sys_rst || cs) begin
      is_read_q  <= 1'b0;
      reg_sel_q  <= 2'd0;
      base_q     <= '0;
      offset_q   <= '0;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      rx_cnt_q   <= 8'd7;
      tx_cnt_q   <= 8'd0;
      tx_upd_q   <= 1'b0;
      tx_data_q  <= '0;
      pop_q      <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      is_read_q  <= is_read_d;
      reg_sel_q  <= reg_sel_d;
      base_q     <= base_d;
      offset_q   <= offset_d;
      addr_q     <= addr_d;
      addr_vld_q <= addr_vld_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_upd_q   <= tx_upd_d;
      tx_data_q  <= tx_data_d;
      pop_q      <= pop_d;
      tx_done_q  <= tx_done;
    end
  end

  // Deselect keeps the register file; only reset clears it.
  always_ff @(posedge sclk) begin
    if (sys_rst) begin
      dummy_q    <= DUMMY_CYCLES;
      wrap_q     <= 16'd0;
      underrun_q <= 1'b0;
    end else if (!cs) begin
      dummy_q    <= dummy_d;
      wrap_q     <= wrap_d;
      underrun_q <= underrun_d;
    end
  end

  assign rx_counter         = rx_cnt_q;
  assign rx_counter_upd     = rx_upd & ~cs & ~sys_rst;
  assign tx_counter         = tx_cnt_q;
  assign tx_counter_upd     = tx_upd_q;
  assign tx_data            = tx_data_q;
  assign tx_data_valid      = tx_upd_q;
  assign ctrl_rd_wr         = (state_q == S_DUMMY) ||
                              (state_q == S_DATA_TX);
  assign ctrl_addr          = addr_q;
  assign ctrl_addr_valid    = addr_vld_q;
  assign ctrl_data_rx       = rx_data[DATA_WIDTH-1:0];
  assign ctrl_data_rx_valid = wr_strobe & ~cs & ~sys_rst;
  assign ctrl_data_tx_ready = pop_q;
  assign wrap_length        = wrap_q;
  assign underrun           = underrun_q;

endmodule

// File: tb/tb_spi_slave_burst_controller.sv
// Bench for spi_slave_burst_controller: frame-level reference model
// compared every cycle, plus directed literal expectations.
module tb_spi_slave_burst_controller;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam logic [31:0] UD = 32'hDEAD_BEEF;

  logic        sclk = 1'b0;
  logic        sys_rst;
  logic        cs;
  logic [7:0]  rx_counter;
  logic        rx_counter_upd;
  logic [31:0] rx_data;
  logic        rx_data_valid;
  logic [7:0]  tx_counter;
  logic        tx_counter_upd;
  logic [31:0] tx_data;
  logic        tx_data_valid;
  logic        tx_done;
  logic        ctrl_rd_wr;
  logic [23:0] ctrl_addr;
  logic        ctrl_addr_valid;
  logic [31:0] ctrl_data_rx;
  logic        ctrl_data_rx_valid;
  logic [31:0] ctrl_data_tx;
  logic        ctrl_data_tx_valid;
  logic        ctrl_data_tx_ready;
  logic [15:0] wrap_length;
  logic        underrun;

  spi_slave_burst_controller #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DUMMY_CYCLES(8'd7),
    .UNDERRUN_DATA(UD)
  ) dut (
    .sclk(sclk),
    .sys_rst(sys_rst),
    .cs(cs),
    .rx_counter(rx_counter),
    .rx_counter_upd(rx_counter_upd),
    .rx_data(rx_data),
    .rx_data_valid(rx_data_valid),
    .tx_counter(tx_counter),
    .tx_counter_upd(tx_counter_upd),
    .tx_data(tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_done(tx_done),
    .ctrl_rd_wr(ctrl_rd_wr),
    .ctrl_addr(ctrl_addr),
    .ctrl_addr_valid(ctrl_addr_valid),
    .ctrl_data_rx(ctrl_data_rx),
    .ctrl_data_rx_valid(ctrl_data_rx_valid),
    .ctrl_data_tx(ctrl_data_tx),
    .ctrl_data_tx_valid(ctrl_data_tx_valid),
    .ctrl_data_tx_ready(ctrl_data_tx_ready),
    .wrap_length(wrap_length),
    .underrun(underrun)
  );

  always #5 sclk = ~sclk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // ---------------- frame-level reference model ----------------
  typedef enum int {K_WR, K_RD, K_WREG, K_RREG, K_IGN} kind_e;

  bit          m_active;
  kind_e       m_kind;
  int          m_fidx;
  int          m_k;
  logic [1:0]  m_r;
  logic [23:0] m_base;
  logic [7:0]  m_dummy;
  logic [15:0] m_wrap;
  bit          m_ur;
  bit          m_done_pend;

  logic [7:0]  e_rxcnt;
  logic [7:0]  e_txcnt;
  logic        e_txv;
  logic [31:0] e_txd;
  logic [23:0] e_addr;
  logic        e_addrv;
  logic        e_pop;

  function automatic logic [23:0] word_addr(int k);
    int off = 0;
    for (int i = 0; i < k; i++) begin
      off += DW / 8;
      if (m_wrap != 0 && off >= int'(m_wrap)) off = 0;
    end
    return m_base + 24'(off);
  endfunction

  function automatic logic [7:0] reg_val(logic [1:0] r);
    case (r)
      2'd0: return m_dummy;
      2'd1: return m_wrap[7:0];
      2'd2: return m_wrap[15:8];
      default: return {7'b0, m_ur};
    endcase
  endfunction

  task automatic frame_clear();
    m_active    = 0;
    m_done_pend = 0;
    e_rxcnt     = 8'd7;
    e_txcnt     = 8'd0;
    e_txd       = 32'd0;
    e_addr      = 24'd0;
  endtask

  task automatic load_word();
    e_txv   = 1;
    e_txcnt = 8'(DW - 1);
    if (ctrl_data_tx_valid) begin
      e_txd = ctrl_data_tx;
      e_pop = 1;
    end else begin
      e_txd = UD;
      m_ur  = 1;
    end
  endtask

  task automatic decode(logic [7:0] c);
    m_active = 1;
    m_fidx   = 1;
    if (c == 8'h02) begin
      m_kind = K_WR; e_rxcnt = 8'(AW - 1);
    end else if (c == 8'h0B) begin
      m_kind = K_RD; e_rxcnt = 8'(AW - 1);
    end else if (c[7:2] == 6'd4) begin
      m_kind = K_WREG; m_r = c[1:0]; e_rxcnt = 8'd7;
    end else if (c[7:2] == 6'd8) begin
      m_kind  = K_RREG; m_r = c[1:0];
      e_txv   = 1;
      e_txcnt = 8'd7;
      e_txd   = {24'd0, reg_val(c[1:0])};
    end else begin
      m_kind = K_IGN;
    end
  endtask

  always @(posedge sclk) begin
    bit done_now;
    e_addrv = 0;
    e_txv   = 0;
    e_pop   = 0;
    if (sys_rst) begin
      frame_clear();
      m_dummy = 8'd7;
      m_wrap  = 16'd0;
      m_ur    = 0;
    end else if (cs) begin
      frame_clear();
    end else begin
      done_now    = m_done_pend;
      m_done_pend = tx_done;
      if (!m_active) begin
        if (rx_data_valid) decode(rx_data[7:0]);
      end else begin
        case (m_kind)
          K_WR: if (rx_data_valid) begin
            if (m_fidx == 1) begin
              m_base = rx_data[23:0];
              m_k    = 0;
            end else begin
              m_k++;
            end
            e_addr  = word_addr(m_k);
            e_addrv = 1;
            e_rxcnt = 8'(DW - 1);
            m_fidx++;
          end
          K_RD: begin
            if (m_fidx == 1 && rx_data_valid) begin
              m_base  = rx_data[23:0];
              m_k     = 0;
              e_addr  = m_base;
              e_addrv = 1;
              e_rxcnt = m_dummy;
              m_fidx++;
            end else if (m_fidx == 2 && rx_data_valid) begin
              load_word();
              m_fidx++;
            end else if (m_fidx == 3 && done_now) begin
              m_k++;
              e_addr  = word_addr(m_k);
              e_addrv = 1;
              load_word();
            end
          end
          K_WREG: if (rx_data_valid) begin
            case (m_r)
              2'd0: m_dummy = rx_data[7:0];
              2'd1: m_wrap[7:0] = rx_data[7:0];
              2'd2: m_wrap[15:8] = rx_data[7:0];
              default: if (rx_data[0]) m_ur = 0;
            endcase
            m_active = 0;
            e_rxcnt  = 8'd7;
          end
          K_RREG: if (done_now) m_active = 0;
          default: ;
        endcase
      end
    end
  end

  function automatic logic exp_rxupd();
    logic [7:0] c;
    c = rx_data[7:0];
    if (sys_rst || cs || !rx_data_valid) return 1'b0;
    if (!m_active)
      return c == 8'h02 || c == 8'h0B || c[7:2] == 6'd4;
    return m_kind == K_WR || m_kind == K_WREG ||
           (m_kind == K_RD && m_fidx == 1);
  endfunction

  function automatic logic exp_wrv();
    return !sys_rst && !cs && rx_data_valid && m_active &&
           m_kind == K_WR && m_fidx >= 2;
  endfunction

  // ---------------- per-cycle compare + logs ----------------
  logic [31:0] addr_log[$];
  logic [31:0] wr_log[$];
  logic [31:0] tx_log[$];
  int          pop_cnt = 0;

  always @(negedge sclk) begin
    if (chk_en) begin
      chk("rx_counter", rx_counter, e_rxcnt);
      chk("rx_counter_upd", rx_counter_upd, exp_rxupd());
      chk("tx_counter", tx_counter, e_txcnt);
      chk("tx_counter_upd", tx_counter_upd, e_txv);
      chk("tx_data_valid", tx_data_valid, e_txv);
      chk("tx_data", tx_data, e_txd);
      chk("ctrl_rd_wr", ctrl_rd_wr,
          m_active && m_kind == K_RD && m_fidx >= 2);
      chk("ctrl_addr", ctrl_addr, e_addr);
      chk("ctrl_addr_valid", ctrl_addr_valid, e_addrv);
      chk("ctrl_data_rx_valid", ctrl_data_rx_valid, exp_wrv());
      if (exp_wrv())
        chk("ctrl_data_rx", ctrl_data_rx, rx_data);
      chk("ctrl_data_tx_ready", ctrl_data_tx_ready, e_pop);
      chk("wrap_length", wrap_length, m_wrap);
      chk("underrun", underrun, m_ur);
      if (ctrl_addr_valid) addr_log.push_back(32'(ctrl_addr));
      if (ctrl_data_rx_valid) wr_log.push_back(ctrl_data_rx);
      if (tx_data_valid) tx_log.push_back(tx_data);
      if (ctrl_data_tx_ready) pop_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic field(input logic [31:0] v);
    rx_data       = v;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    tick();
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    tick();
  endtask

  task automatic tx_word(input logic [31:0] d, input logic v);
    ctrl_data_tx       = d;
    ctrl_data_tx_valid = v;
    done_pulse();
  endtask

  task automatic deselect();
    cs = 1'b1;
    tick();
    tick();
    cs = 1'b0;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    wr_log.delete();
    tx_log.delete();
    pop_cnt = 0;
  endtask

  task automatic chk_log(input string nm,
                         input logic [31:0] got[$],
                         input logic [31:0] want[$]);
    chk({nm, "_len"}, 64'(got.size()), 64'(want.size()));
    for (int i = 0; i < want.size(); i++)
      chk(nm, i < got.size() ? got[i] : 32'hFFFF_FFFF, want[i]);
  endtask

  initial begin
    sys_rst            = 1'b1;
    cs                 = 1'b1;
    rx_data            = 32'd0;
    rx_data_valid      = 1'b0;
    tx_done            = 1'b0;
    ctrl_data_tx       = 32'd0;
    ctrl_data_tx_valid = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    chk("rst_rx_counter", rx_counter, 8'd7);
    chk("rst_wrap", wrap_length, 16'd0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_addr", ctrl_addr, 24'd0);
    cs = 1'b0;
    tick();

    // Write burst
    clear_logs();
    field(32'h02);
    field(32'h000100);
    field(32'h0000_000A);
    field(32'h0000_000B);
    field(32'h0000_000C);
    chk_log("wr_addr", addr_log, '{32'h100, 32'h104, 32'h108, 32'h10C});
    chk_log("wr_data", wr_log, '{32'hA, 32'hB, 32'hC});
    deselect();

    // Wrap 8 bytes, read burst from base 4
    clear_logs();
    field(32'h11);
    field(32'h08);
    chk("wrap_set", wrap_length, 16'd8);
    field(32'h0B);
    field(32'h000004);
    chk("dummy_rxcnt", rx_counter, 8'd7);
    chk("dummy_rdwr", ctrl_rd_wr, 1'b1);
    ctrl_data_tx       = 32'h1111_0000;
    ctrl_data_tx_valid = 1'b1;
    field(32'h0);
    tx_word(32'h1111_0001, 1'b1);
    tx_word(32'h1111_0002, 1'b1);
    tx_word(32'h1111_0003, 1'b1);
    chk_log("rd_addr", addr_log, '{32'h4, 32'h8, 32'h4, 32'h8});
    chk_log("rd_data", tx_log, '{32'h1111_0000, 32'h1111_0001,
                                 32'h1111_0002, 32'h1111_0003});
    chk("rd_pops", 64'(pop_cnt), 64'd4);
    deselect();

    // Underrun on second word
    clear_logs();
    field(32'h0B);
    field(32'h000020);
    ctrl_data_tx       = 32'h2222_0000;
    ctrl_data_tx_valid = 1'b1;
    field(32'h0);
    tx_word(32'h2222_0001, 1'b0);
    chk_log("ur_data", tx_log, '{32'h2222_0000, UD});
    chk("ur_pops", 64'(pop_cnt), 64'd1);
    chk("ur_flag", underrun, 1'b1);
    deselect();
    field(32'h23);
    chk("rdreg3", tx_data, 32'h1);
    chk("rdreg3_cnt", tx_counter, 8'd7);
    done_pulse();
    field(32'h13);
    field(32'h01);
    chk("ur_clear", underrun, 1'b0);
    field(32'h21);
    chk("rdreg1", tx_data, 32'h8);
    done_pulse();
    deselect();

    // Deselect mid write burst
    field(32'h02);
    field(32'h000200);
    field(32'h0000_0011);
    deselect();
    chk("cs_rxcnt", rx_counter, 8'd7);
    chk("cs_addr", ctrl_addr, 24'd0);
    field(32'h20);
    chk("cs_dummy", tx_data, 32'h7);
    chk("cs_wrap", wrap_length, 16'd8);
    done_pulse();

    // Reset mid read burst
    field(32'h10);
    field(32'h03);
    field(32'h0B);
    field(32'h000040);
    chk("new_dummy", rx_counter, 8'd3);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    tick();
    field(32'h20);
    chk("rst_dummy", tx_data, 32'h7);
    chk("rst_wrap2", wrap_length, 16'd0);
    done_pulse();
    deselect();

    // Unknown command
    clear_logs();
    field(32'h55);
    field(32'h02);
    field(32'h10);
    field(32'hAB);
    chk("ign_addr", 64'(addr_log.size()), 64'd0);
    chk("ign_wr", 64'(wr_log.size()), 64'd0);
    deselect();
    field(32'h20);
    chk("after_ign", tx_data, 32'h7);
    done_pulse();
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
